// File: rtl/debug_pkg.sv
// Shared constants for the pipeline debug controller: host command codes,
// FSM state encodings and the frame length helper.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_HALTED  = 3'd5;

    // Snapshot words plus the cycle-count word, in bytes.
    function automatic int frame_bytes(input int bits_size, input int num_words);
        return (num_words + 1) * bits_size / 8;
    endfunction

endpackage

// File: rtl/dbg_frame_serializer.sv
// Shadow buffer for one debug frame; shifts it out little-endian, one byte
// per valid/ready handshake, and strobes o_done on the final byte.
module dbg_frame_serializer
    import debug_pkg::*;
#(
    parameter int BITS_SIZE = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_load,
    input  logic [NUM_WORDS*BITS_SIZE-1:0] i_snapshot,
    input  logic [BITS_SIZE-1:0]           i_count,
    output logic                           o_tx_valid,
    output logic [7:0]                     o_tx_data,
    input  logic                           i_tx_ready,
    output logic                           o_done
);

    localparam int FB = frame_bytes(BITS_SIZE, NUM_WORDS);
    localparam int FW = FB * 8;
    localparam int CW = $clog2(FB);

    logic [FW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          accept;
    logic          last;

    assign accept = valid_q & i_tx_ready;
    assign last   = (cnt_q == CW'(FB - 1));

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        if (i_load) begin
            shadow_d = {i_count, i_snapshot};
            cnt_d    = '0;
            valid_d  = 1'b1;
        end else if (accept) begin
            // Byte 0 always sits in the low lane, so the output mux is free.
            shadow_d = shadow_q >> 8;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
        end
    end

    assign o_tx_valid = valid_q;
    assign o_tx_data  = shadow_q[7:0];
    assign o_done     = accept & last;

endmodule

// File: rtl/debug_step_unit.sv
// Host-driven debug controller: steps the pipeline, watches the WB halt flag
// and streams a latch snapshot plus cycle count back to the host.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a host command
//   RUN     | step every cycle until halt is seen
//   STEP    | single step cycle
//   CAPTURE | load snapshot and cycle count into the serializer
//   SEND    | streaming frame bytes to the host
//   HALTED  | core halted; only dump is honoured, leave via reset
module debug_step_unit
    import debug_pkg::*;
#(
    parameter int BITS_SIZE = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_cmd_valid,
    input  logic [7:0]                     i_cmd_data,
    output logic                           o_cmd_ready,
    input  logic                           i_halt,
    input  logic [NUM_WORDS*BITS_SIZE-1:0] i_snapshot,
    output logic                           o_step,
    output logic                           o_tx_valid,
    output logic [7:0]                     o_tx_data,
    input  logic                           i_tx_ready,
    output logic                           o_halted,
    output logic [BITS_SIZE-1:0]           o_cycle_count
);

    logic [2:0]           state_q, state_d;
    logic                 ret_halt_q, ret_halt_d;
    logic                 watch_q, watch_d;
    logic [BITS_SIZE-1:0] count_q, count_d;
    logic                 load;
    logic                 ser_done;
    logic                 cmd_take;

    assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign cmd_take    = i_cmd_valid & o_cmd_ready;
    assign o_step      = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_halted    = (state_q == ST_HALTED);

    always_comb begin
        state_d    = state_q;
        ret_halt_d = ret_halt_q;
        watch_d    = watch_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_take) begin
                    case (i_cmd_data)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: begin
                            state_d    = ST_CAPTURE;
                            ret_halt_d = 1'b0;
                            watch_d    = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d    = ST_CAPTURE;
                    ret_halt_d = 1'b1;
                    watch_d    = 1'b0;
                end
            end
            ST_STEP: begin
                // A halt that lands in the capture cycle still counts for a single step.
                state_d    = ST_CAPTURE;
                ret_halt_d = i_halt;
                watch_d    = 1'b1;
            end
            ST_CAPTURE: begin
                load    = 1'b1;
                state_d = ST_SEND;
                if (watch_q && i_halt) ret_halt_d = 1'b1;
            end
            ST_SEND: begin
                if (ser_done) state_d = ret_halt_q ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                if (cmd_take && (i_cmd_data == CMD_DUMP)) begin
                    state_d    = ST_CAPTURE;
                    ret_halt_d = 1'b1;
                    watch_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (o_step && (count_q != '1)) count_d = count_q + BITS_SIZE'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ret_halt_q <= 1'b0;
            watch_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ret_halt_q <= ret_halt_d;
            watch_q    <= watch_d;
            count_q    <= count_d;
        end
    end

    assign o_cycle_count = count_q;

    dbg_frame_serializer #(
        .BITS_SIZE(BITS_SIZE),
        .NUM_WORDS(NUM_WORDS)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (load),
        .i_snapshot (i_snapshot),
        .i_count    (count_q),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_done     (ser_done)
    );

endmodule
